// File: rtl/bandeja_arbiter_if.sv
// Handshake and status bundle between the tray arbiter and its requesters/consumers.
// slave: arbiter side; master: requester/monitor side.
interface bandeja_arbiter_if;
    logic       seal_req;
    logic       refill_req;
    logic       restock;
    logic       seal_gnt;
    logic       refill_gnt;
    logic [5:0] count;
    logic [7:0] stock;
    logic       low;
    logic       empty;
    logic       refill_need;
    logic       alarm;

    modport slave (
        input  seal_req,
        input  refill_req,
        input  restock,
        output seal_gnt,
        output refill_gnt,
        output count,
        output stock,
        output low,
        output empty,
        output refill_need,
        output alarm
    );

    modport master (
        output seal_req,
        output refill_req,
        output restock,
        input  seal_gnt,
        input  refill_gnt,
        input  count,
        input  stock,
        input  low,
        input  empty,
        input  refill_need,
        input  alarm
    );
endinterface

// File: rtl/bandeja_arbiter.sv
// Tray arbiter: serialises seal/refill accesses and owns tray/stock counters; BCD_OUT_EN adds registered BCD display outputs.
// Latency: request sampled in IDLE -> one-cycle grant on the next cycle with counters already updated; max one grant per 2 cycles.
// Backpressure: requesters hold req until their grant; ineligible requests are ignored, never queued.
module bandeja_arbiter #(
    parameter int TRAY_MAX   = 25,
    parameter int TRAY_INIT  = 15,
    parameter int REFILL_QTY = 20,
    parameter int LOW_LEVEL  = 5,
    parameter int STOCK_INIT = 40
) (
    input  logic              clk,
    input  logic              reset,
    bandeja_arbiter_if.slave  bus
`ifdef BCD_OUT_EN
    ,
    output logic [3:0]        count_tens,
    output logic [3:0]        count_units,
    output logic [3:0]        stock_hund,
    output logic [3:0]        stock_tens,
    output logic [3:0]        stock_units
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEAL,
        ST_REFILL,
        ST_ALARM
    } state_t;

    state_t     state_q;
    logic [5:0] count_q;
    logic [7:0] stock_q;
    logic       last_seal_q;
    logic       seal_gnt_q;
    logic       refill_gnt_q;
    logic       alarm_q;

    logic       seal_elig;
    logic       refill_elig;
    logic       seal_wins;
    logic       starve;
    logic [8:0] room;
    logic [8:0] add;

    assign seal_elig   = bus.seal_req && (count_q != 6'd0);
    assign refill_elig = bus.refill_req && (stock_q != 8'd0) && (count_q < 6'(TRAY_MAX));
    // Round-robin: seal wins a tie only if refill was granted last.
    assign seal_wins   = seal_elig && (!refill_elig || !last_seal_q);
    assign starve      = bus.seal_req && (count_q == 6'd0) && (stock_q == 8'd0);

    // Batch size is bounded by the quota, the free space and what the dispenser still holds.
    always_comb begin
        room = 9'(TRAY_MAX) - {3'b000, count_q};
        add  = 9'(REFILL_QTY);
        if (room < add) begin
            add = room;
        end
        if ({1'b0, stock_q} < add) begin
            add = {1'b0, stock_q};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            count_q      <= 6'(TRAY_INIT);
            stock_q      <= 8'(STOCK_INIT);
            last_seal_q  <= 1'b0;
            seal_gnt_q   <= 1'b0;
            refill_gnt_q <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            seal_gnt_q   <= 1'b0;
            refill_gnt_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.restock) begin
                        stock_q <= 8'(STOCK_INIT);
                    end else if (seal_wins) begin
                        state_q     <= ST_SEAL;
                        seal_gnt_q  <= 1'b1;
                        count_q     <= count_q - 6'd1;
                        last_seal_q <= 1'b1;
                    end else if (refill_elig) begin
                        state_q      <= ST_REFILL;
                        refill_gnt_q <= 1'b1;
                        count_q      <= 6'({3'b000, count_q} + add);
                        stock_q      <= 8'({1'b0, stock_q} - add);
                        last_seal_q  <= 1'b0;
                    end else if (starve) begin
                        state_q <= ST_ALARM;
                        alarm_q <= 1'b1;
                    end
                end
                ST_SEAL, ST_REFILL: begin
                    state_q <= ST_IDLE;
                    if (bus.restock) begin
                        stock_q <= 8'(STOCK_INIT);
                    end
                end
                ST_ALARM: begin
                    if (bus.restock) begin
                        stock_q <= 8'(STOCK_INIT);
                        state_q <= ST_IDLE;
                        alarm_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.seal_gnt    = seal_gnt_q;
    assign bus.refill_gnt  = refill_gnt_q;
    assign bus.alarm       = alarm_q;
    assign bus.count       = count_q;
    assign bus.stock       = stock_q;
    assign bus.low         = (count_q <= 6'(LOW_LEVEL));
    assign bus.empty       = (count_q == 6'd0);
    assign bus.refill_need = bus.low && (stock_q != 8'd0) && (count_q < 6'(TRAY_MAX));

`ifdef BCD_OUT_EN
    // Display digits trail the binary counters by one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_tens  <= 4'(TRAY_INIT / 10);
            count_units <= 4'(TRAY_INIT % 10);
            stock_hund  <= 4'(STOCK_INIT / 100);
            stock_tens  <= 4'((STOCK_INIT / 10) % 10);
            stock_units <= 4'(STOCK_INIT % 10);
        end else begin
            count_tens  <= 4'(count_q / 6'd10);
            count_units <= 4'(count_q % 6'd10);
            stock_hund  <= 4'(stock_q / 8'd100);
            stock_tens  <= 4'((stock_q / 8'd10) % 8'd10);
            stock_units <= 4'(stock_q % 8'd10);
        end
    end
`endif

endmodule

// File: tb/tb_bandeja_arbiter.sv
// Directed bench for bandeja_arbiter: a transaction-level tray model checked every cycle, plus literal checkpoints.
module tb_bandeja_arbiter;
    localparam int TRAY_MAX   = 25;
    localparam int TRAY_INIT  = 15;
    localparam int REFILL_QTY = 20;
    localparam int LOW_LEVEL  = 5;
    localparam int STOCK_INIT = 40;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    bit   run   = 1'b0;

    bandeja_arbiter_if bus();

`ifdef BCD_OUT_EN
    logic [3:0] count_tens, count_units, stock_hund, stock_tens, stock_units;
`endif

    bandeja_arbiter #(
        .TRAY_MAX  (TRAY_MAX),
        .TRAY_INIT (TRAY_INIT),
        .REFILL_QTY(REFILL_QTY),
        .LOW_LEVEL (LOW_LEVEL),
        .STOCK_INIT(STOCK_INIT)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
`ifdef BCD_OUT_EN
        ,
        .count_tens (count_tens),
        .count_units(count_units),
        .stock_hund (stock_hund),
        .stock_tens (stock_tens),
        .stock_units(stock_units)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int n_seal = 0;
    int n_refill = 0;
    int order[$];

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Tray model: tracks what the tray and dispenser hold, who was served last,
    // whether a grant is being shown this cycle, and whether the line is starved.
    int m_count = TRAY_INIT;
    int m_stock = STOCK_INIT;
    bit m_last_seal = 1'b0;
    bit m_sg = 1'b0;
    bit m_rg = 1'b0;
    bit m_alarm = 1'b0;
    bit nx_sg, nx_rg, want_seal, want_refill;
    int m_add;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count = TRAY_INIT;
            m_stock = STOCK_INIT;
            m_last_seal = 1'b0;
            m_sg = 1'b0;
            m_rg = 1'b0;
            m_alarm = 1'b0;
        end else begin
            nx_sg = 1'b0;
            nx_rg = 1'b0;
            if (m_sg || m_rg) begin
                if (bus.restock) m_stock = STOCK_INIT;
            end else if (m_alarm) begin
                if (bus.restock) begin
                    m_stock = STOCK_INIT;
                    m_alarm = 1'b0;
                end
            end else if (bus.restock) begin
                m_stock = STOCK_INIT;
            end else begin
                want_seal   = bus.seal_req && m_count > 0;
                want_refill = bus.refill_req && m_stock > 0 && m_count < TRAY_MAX;
                if (want_seal && (!want_refill || !m_last_seal)) begin
                    nx_sg = 1'b1;
                    m_count = m_count - 1;
                    m_last_seal = 1'b1;
                end else if (want_refill) begin
                    m_add = REFILL_QTY;
                    if (TRAY_MAX - m_count < m_add) m_add = TRAY_MAX - m_count;
                    if (m_stock < m_add) m_add = m_stock;
                    nx_rg = 1'b1;
                    m_count = m_count + m_add;
                    m_stock = m_stock - m_add;
                    m_last_seal = 1'b0;
                end else if (bus.seal_req && m_count == 0 && m_stock == 0) begin
                    m_alarm = 1'b1;
                end
            end
            m_sg = nx_sg;
            m_rg = nx_rg;
        end
    end

    always @(negedge clk) begin
        if (run && reset) begin
            chk("seal_gnt",    bus.seal_gnt,    int'(m_sg));
            chk("refill_gnt",  bus.refill_gnt,  int'(m_rg));
            chk("alarm",       bus.alarm,       int'(m_alarm));
            chk("count",       bus.count,       m_count);
            chk("stock",       bus.stock,       m_stock);
            chk("low",         bus.low,         int'(m_count <= LOW_LEVEL));
            chk("empty",       bus.empty,       int'(m_count == 0));
            chk("refill_need", bus.refill_need,
                int'(m_count <= LOW_LEVEL && m_stock != 0 && m_count < TRAY_MAX));
            if (bus.seal_gnt === 1'b1) begin
                n_seal++;
                order.push_back(1);
            end
            if (bus.refill_gnt === 1'b1) begin
                n_refill++;
                order.push_back(0);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input bit r, input bit k);
        bus.seal_req   = s;
        bus.refill_req = r;
        bus.restock    = k;
    endtask

    int base;
    int s0;
    int exp_ord[4] = '{1, 0, 1, 0};

    initial begin
        drive(0, 0, 0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        run = 1'b1;

        chk("rst_count", bus.count, 15);
        chk("rst_stock", bus.stock, 40);
        chk("rst_seal_gnt", bus.seal_gnt, 0);
        chk("rst_refill_gnt", bus.refill_gnt, 0);
        chk("rst_alarm", bus.alarm, 0);
        chk("rst_low", bus.low, 0);
        chk("rst_empty", bus.empty, 0);
        chk("rst_refill_need", bus.refill_need, 0);

        // Both held: seal first, then refill wins the next tie.
        base = order.size();
        drive(1, 1, 0);
        cyc(8);
        drive(0, 0, 0);
        chk("rr_grants", order.size() - base, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < order.size()) chk("rr_order", order[base + i], exp_ord[i]);
        chk("rr_count", bus.count, 25);
        chk("rr_stock", bus.stock, 28);

        s0 = n_seal;
        drive(1, 0, 0);
        cyc(10);
        drive(0, 0, 0);
        chk("seal10_pulses", n_seal - s0, 5);
        chk("seal10_count", bus.count, 20);

        drive(1, 0, 0);
        cyc(30);
        drive(0, 0, 0);
        chk("at5_count", bus.count, 5);
        chk("at5_low", bus.low, 1);
        chk("at5_refill_need", bus.refill_need, 1);

        s0 = n_refill;
        drive(0, 1, 0);
        cyc(2);
        drive(0, 0, 0);
        chk("refill_pulses", n_refill - s0, 1);
        chk("refill_count", bus.count, 25);
        chk("refill_stock", bus.stock, 8);
        drive(0, 1, 0);
        cyc(4);
        drive(0, 0, 0);
        chk("full_no_grant", n_refill - s0, 1);

        // Drain to count 12 with stock 3, then a stock-limited refill.
        drive(1, 0, 0); cyc(10); drive(0, 0, 0);
        drive(0, 1, 0); cyc(2);  drive(0, 0, 0);
        chk("partial_stock", bus.stock, 3);
        drive(1, 0, 0); cyc(26); drive(0, 0, 0);
        chk("pre_cap_count", bus.count, 12);
        s0 = n_refill;
        drive(0, 1, 0); cyc(2); drive(0, 0, 0);
        chk("stockcap_count", bus.count, 15);
        chk("stockcap_stock", bus.stock, 0);
        chk("stockcap_need", bus.refill_need, 0);
        drive(0, 1, 0); cyc(4); drive(0, 0, 0);
        chk("nostock_no_grant", n_refill - s0, 1);

        // Starvation alarm and restock recovery.
        s0 = n_seal;
        drive(1, 0, 0);
        cyc(32);
        drive(0, 0, 0);
        chk("starve_pulses", n_seal - s0, 15);
        chk("alarm_set", bus.alarm, 1);
        chk("alarm_empty", bus.empty, 1);
        cyc(2);
        chk("alarm_sticky", bus.alarm, 1);
        drive(0, 0, 1);
        cyc(1);
        drive(0, 0, 0);
        chk("restock_alarm", bus.alarm, 0);
        chk("restock_stock", bus.stock, 40);
        drive(0, 1, 0); cyc(2); drive(0, 0, 0);
        chk("post_restock_count", bus.count, 20);
        chk("post_restock_stock", bus.stock, 20);

        // Asynchronous reset in the middle of a refill grant.
        drive(0, 1, 0);
        @(posedge clk);
        #2;
        chk("mid_refill_gnt", bus.refill_gnt, 1);
        chk("mid_refill_count", bus.count, 25);
        reset = 1'b0;
        drive(0, 0, 0);
        #1;
        chk("arst_refill_gnt", bus.refill_gnt, 0);
        chk("arst_count", bus.count, 15);
        chk("arst_stock", bus.stock, 40);
        @(negedge clk);
        #1 reset = 1'b1;

        // Restock in IDLE blocks a grant for that edge.
        drive(0, 1, 0); cyc(2); drive(0, 0, 0);
        chk("pre_prio_stock", bus.stock, 30);
        drive(1, 0, 1);
        cyc(1);
        drive(1, 0, 0);
        chk("prio_no_gnt", bus.seal_gnt, 0);
        chk("prio_stock", bus.stock, 40);
        cyc(1);
        drive(0, 0, 0);
        chk("prio_then_gnt", bus.seal_gnt, 1);
        chk("prio_count", bus.count, 24);
        cyc(2);

        run = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/bandeja_arbiter.md
# bandeja_arbiter

Arbiter and bookkeeper for the shared stopper tray (bandeja) of the bottling line. Two requesters share the tray: the sealing station takes one stopper per bottle, and the dispenser deposits a batch of stoppers. The block serialises their accesses with a req/grant handshake and owns the tray and dispenser-stock counters. It also raises the low, empty and alarm flags consumed by the production and dispenser FSMs and the display path.

## Interface
Parameters:
- TRAY_MAX, 25: tray capacity in stoppers (≤ 63).
- TRAY_INIT, 15: tray count after reset (≤ TRAY_MAX).
- REFILL_QTY, 20: stoppers moved per refill grant (upper bound).
- LOW_LEVEL, 5: `low` asserted when count ≤ LOW_LEVEL.
- STOCK_INIT, 40: dispenser stock after reset or restock (≤ 255).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces the reset state immediately.
- seal_req  in  1  sealing station requests one stopper; held until seal_gnt.
- refill_req  in  1  dispenser requests to deposit; held until refill_gnt.
- restock  in  1  one-cycle pulse; reloads stock to STOCK_INIT and clears alarm.
- seal_gnt  out  1  one-cycle grant; one stopper removed.
- refill_gnt  out  1  one-cycle grant; batch added.
- count  out  6  stoppers in tray.
- stock  out  8  stoppers left in dispenser.
- low  out  1  count ≤ LOW_LEVEL.
- empty  out  1  count == 0.
- refill_need  out  1  low && stock != 0 && count < TRAY_MAX; drives dispenser FSM.
- alarm  out  1  starvation alarm, sticky.

## Operation
- States: IDLE, SEAL, REFILL, ALARM. Moore outputs: seal_gnt = (state==SEAL), refill_gnt = (state==REFILL), alarm = (state==ALARM).
- Eligibility in IDLE:
  - seal eligible = seal_req && count != 0.
  - refill eligible = refill_req && stock != 0 && count < TRAY_MAX.
  - Non-eligible requests are ignored, never queued.
- Arbitration, both eligible: round-robin on a 1-bit last-grant register, which resets to "refill", so seal wins first. Only one eligible: it wins.
- IDLE→SEAL: count ← count − 1; last ← seal.
- IDLE→REFILL:
  - add = min(REFILL_QTY, TRAY_MAX − count, stock).
  - count ← count + add; stock ← stock − add; last ← refill.
  - All arithmetic uses 9-bit intermediates; count never exceeds TRAY_MAX, stock never underflows.
- IDLE→ALARM: seal_req && count == 0 && stock == 0 && !restock.
- SEAL, REFILL → IDLE unconditionally after one cycle.
- ALARM: no grants; leaves to IDLE on the edge sampling restock=1.
- restock in any state: stock ← STOCK_INIT on that edge. Sampled in IDLE, it takes priority: no grant is issued that edge and state stays IDLE. Sampled in SEAL/REFILL, it does not alter the pending return to IDLE.
- Handshake: a requester drops req in the cycle after its grant. A req still high in the IDLE cycle following a grant is treated as a new request.

## Timing
- Reset values: state IDLE, count=TRAY_INIT, stock=STOCK_INIT, last=refill, seal_gnt=0, refill_gnt=0, alarm=0. With defaults: low=0, empty=0, refill_need=0.
- Latency: req sampled high at edge N in IDLE → grant high during cycle N..N+1; count/stock already updated in the same cycle.
- Throughput: at most one grant per 2 cycles (grant cycle + IDLE cycle).
- low, empty, refill_need: combinational from count/stock registers; valid the cycle the counters change.
- Reset asserted mid-grant: grant drops immediately; counters return to reset values; a partial refill is not retained.

## Configuration
- BCD_OUT_EN defined:
  - Adds outputs count_tens[3:0], count_units[3:0], stock_hund[3:0], stock_tens[3:0], stock_units[3:0] for the display mux.
  - These are registered binary-to-BCD conversions updated with the counters, one cycle after the count/stock change; reset values are the BCD of TRAY_INIT/STOCK_INIT.
- BCD_OUT_EN undefined: those ports and their logic are absent; binary count/stock only.

## Test plan
- Reset with defaults → count=15, stock=40, all grants and alarm 0. Hold seal_req 10 cycles → 5 seal_gnt pulses, every other cycle; count=10.
- From count=5: refill_req → low=1 and refill_need=1 before the request; one refill_gnt; count=25, stock=20. A further refill_req with count=25 → no grant.
- seal_req and refill_req both held, count=10 → grants alternate seal, refill, seal, …; first grant is seal.
- count=12, stock=3, refill → add=3: count=15, stock=0, refill_need=0. Later refill_req → no grant.
- count=0, stock=0, seal_req → alarm=1 on next edge, no grants. restock pulse → stock=40, state IDLE next edge; refill then succeeds.
- Assert reset during the REFILL cycle → refill_gnt falls without waiting for clk; count=15, stock=40 immediately.
